// File: rtl/softmax_norm_sequencer.sv
// Softmax normalisation sequencer: buffers one vector of S5.10 exponents, sums them (S13.10),
// then drives one divider transaction per element and streams the S5.10 quotients out.
module softmax_norm_sequencer #(
    parameter int VEC_LEN     = 8,
    parameter int IDX_W       = $clog2(VEC_LEN),
    parameter int TIMEOUT_CYC = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        div_start,
    output logic [15:0] div_numerator,
    output logic [23:0] div_denominator,
    input  logic [15:0] div_quotient,
    input  logic        div_valid,
    output logic        busy,
    output logic        err_timeout
);
    localparam int CNT_W = IDX_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [23:0] SUM_MAX = 24'h7FFFFF;

    typedef enum logic [1:0] {ST_LOAD, ST_ISSUE, ST_WAIT, ST_OUTPUT} state_t;

    function automatic logic [14:0] clamp_neg(input logic signed [15:0] x);
        return x[15] ? 15'd0 : x[14:0];
    endfunction

    function automatic logic [23:0] sat_add(input logic [23:0] a, input logic [14:0] b);
        logic [24:0] s;
        s = {1'b0, a} + {10'd0, b};
        return (s > {1'b0, SUM_MAX}) ? SUM_MAX : s[23:0];
    endfunction

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   count_q, count_d, n_q, n_d, last_idx;
    logic [23:0]        sum_q, sum_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d, div_start_q, div_start_d;
    logic               busy_q, busy_d, err_timeout_q, err_timeout_d;
    logic [15:0]        out_data_q, out_data_d, div_num_q, div_num_d;
    logic [23:0]        div_den_q, div_den_d;
    logic [15:0]        elem_buf_q [VEC_LEN];
    logic [14:0]        elem;
    logic               accept;

    assign elem     = clamp_neg(in_data);
    assign accept   = (state_q == ST_LOAD) && in_valid && in_ready_q;
    assign last_idx = n_q - CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        count_d       = count_q;
        n_d           = n_q;
        sum_d         = sum_q;
        tmo_d         = tmo_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        div_start_d   = 1'b0;
        div_num_d     = div_num_q;
        div_den_d     = div_den_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    sum_d   = sat_add(sum_q, elem);
                    count_d = count_q + CNT_W'(1);
                    if (in_last || count_q == CNT_W'(VEC_LEN - 1)) begin
                        n_d   = count_q + CNT_W'(1);
                        idx_d = '0;
                        // An all-zero vector has no meaningful quotient: emit zeros without dividing
                        if (sum_d == '0) begin
                            state_d     = ST_OUTPUT;
                            out_valid_d = 1'b1;
                            out_data_d  = '0;
                            out_last_d  = (count_q == '0);
                        end else begin
                            state_d     = ST_ISSUE;
                            div_start_d = 1'b1;
                            div_num_d   = (count_q == '0) ? {1'b0, elem} : elem_buf_q[0];
                            div_den_d   = sum_d;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                tmo_d   = TMO_W'(1);
            end
            ST_WAIT: begin
                // tmo_q counts cycles since div_start, so a timeout result lands TIMEOUT_CYC cycles after it
                if (div_valid) begin
                    state_d     = ST_OUTPUT;
                    out_valid_d = 1'b1;
                    out_data_d  = div_quotient;
                    out_last_d  = ({1'b0, idx_q} == last_idx);
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    state_d       = ST_OUTPUT;
                    out_valid_d   = 1'b1;
                    out_data_d    = '0;
                    out_last_d    = ({1'b0, idx_q} == last_idx);
                    err_timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    if ({1'b0, idx_q} == last_idx) begin
                        state_d     = ST_LOAD;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        count_d     = '0;
                        sum_d       = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        if (sum_q == '0) begin
                            out_last_d = ({1'b0, idx_d} == last_idx);
                        end else begin
                            state_d     = ST_ISSUE;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            div_start_d = 1'b1;
                            div_num_d   = elem_buf_q[idx_d];
                            div_den_d   = sum_q;
                        end
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
        in_ready_d = (state_d == ST_LOAD);
        busy_d     = (state_d != ST_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_LOAD;
            idx_q         <= '0;
            count_q       <= '0;
            n_q           <= '0;
            sum_q         <= '0;
            tmo_q         <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            div_start_q   <= 1'b0;
            div_num_q     <= '0;
            div_den_q     <= '0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            count_q       <= count_d;
            n_q           <= n_d;
            sum_q         <= sum_d;
            tmo_q         <= tmo_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            div_start_q   <= div_start_d;
            div_num_q     <= div_num_d;
            div_den_q     <= div_den_d;
            busy_q        <= busy_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Element storage is datapath only; stale contents are never read before being rewritten
    always_ff @(posedge clk) begin
        if (accept) begin
            elem_buf_q[count_q[IDX_W-1:0]] <= {1'b0, elem};
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_last        = out_last_q;
    assign div_start       = div_start_q;
    assign div_numerator   = div_num_q;
    assign div_denominator = div_den_q;
    assign busy            = busy_q;
    assign err_timeout     = err_timeout_q;

endmodule
